// File: rtl/sram_responder.sv
// sram_responder: bridges a 32-bit CPU MEM-stage access onto a 16-bit SRAM.
// Each access is split into a LOW halfword phase and a HIGH halfword phase of
// WAIT_CYCLES cycles each, followed by one DONE cycle that releases the pipeline.
// Optional macro SRAM_RD_BUF_EN adds a one-entry read buffer that answers a
// repeated read of the same word in zero cycles.
module sram_responder #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [16:0] word_q;
  logic [15:0] wdata_hi;
  logic [31:0] rdata_q;

  logic [16:0] word_in;
  logic        req;
  logic        hit;

  // SRAM word index of the CPU address; wraps naturally at 2^17 words
  assign word_in = 17'((address - BASE_ADDR) >> 2);
  assign req     = rd_en | wr_en;

`ifdef SRAM_RD_BUF_EN
  logic        buf_valid;
  logic [16:0] buf_word;
  logic [31:0] buf_data;

  // A plain read of the buffered word completes in the request cycle
  assign hit       = (state == IDLE) && rd_en && !wr_en && buf_valid && (buf_word == word_in);
  assign read_data = hit ? buf_data : rdata_q;

  // Buffer refilled by each completed read, dropped by any write to its word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (state == IDLE && wr_en && word_in == buf_word) begin
      buf_valid <= 1'b0;
    end else if (state == HIGH && cnt == LAST && !op_wr) begin
      buf_valid <= 1'b1;
      buf_word  <= word_q;
      buf_data  <= {SRAM_DQ_in, rdata_q[15:0]};
    end
  end
`else
  assign hit       = 1'b0;
  assign read_data = rdata_q;
`endif

  // Pipeline stalls from the request cycle until DONE
  assign ready = (state == IDLE) ? (!req || hit) : (state == DONE);

  // Access sequencer; SRAM pins are registered so they change only on phase steps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      word_q      <= '0;
      wdata_hi    <= '0;
      rdata_q     <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            // wr_en wins when both are raised
            op_wr       <= wr_en;
            word_q      <= word_in;
            wdata_hi    <= write_data[31:16];
            cnt         <= '0;
            SRAM_ADDR   <= {word_in, 1'b0};
            SRAM_DQ_out <= write_data[15:0];
            SRAM_DQ_oe  <= wr_en;
            SRAM_WE_N   <= !wr_en;
            state       <= LOW;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            if (!op_wr) rdata_q[15:0] <= SRAM_DQ_in;
            cnt         <= '0;
            SRAM_ADDR   <= {word_q, 1'b1};
            SRAM_DQ_out <= wdata_hi;
            SRAM_WE_N   <= !op_wr;
            state       <= HIGH;
          end else begin
            cnt <= cnt + 4'd1;
            // strobe released for the final cycle so data stays valid past WE_N rise
            if (cnt + 4'd1 == LAST) SRAM_WE_N <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            if (!op_wr) rdata_q[31:16] <= SRAM_DQ_in;
            cnt        <= '0;
            SRAM_DQ_oe <= 1'b0;
            SRAM_WE_N  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == LAST) SRAM_WE_N <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed + randomized checks of sram_responder against a
// word-level memory model. Build with SRAM_RD_BUF_EN to also check the read buffer.
module tb_sram_responder;
  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAT  = 2 * W + 1;
`ifdef SRAM_RD_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
  logic        SRAM_DQ_oe, SRAM_WE_N;

  sram_responder #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // asynchronous SRAM device: halfword array, written while strobed and driven
  bit [15:0] sram [0:262143];
  always @(posedge clk) if (SRAM_DQ_oe && !SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ_out;
  assign SRAM_DQ_in = sram[SRAM_ADDR];

  // reference: 32-bit words by word index, plus last-read-word buffer state
  logic [31:0] ref_mem [int];
  bit          bvalid;
  int          bword;
  int          n_asserts, n_fail;

  function automatic int wkey(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[18:2]);
  endfunction

  function automatic logic [31:0] ref_get(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one request from posedge+1; counts cycles until ready, strobe and oe cycles.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat, output int we_lo, output int oe_hi);
    lat = -1; we_lo = 0; oe_hi = 0; rdat = '0;
    rd_en = r; wr_en = w; address = a; write_data = d;
    for (int n = 0; n <= 4 * LAT; n++) begin
      @(negedge clk);
      if (!SRAM_WE_N) we_lo++;
      if (SRAM_DQ_oe) oe_hi++;
      if (ready) begin lat = n; rdat = read_data; break; end
      @(posedge clk); #1;
      // inputs scrambled mid-access must not matter
      if (n == 2) begin address = $urandom; write_data = $urandom; end
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
  endtask

  // One transaction checked against the model
  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input string tag, output logic [31:0] rdat);
    int lat, wl, oh, k;
    bit exp_hit;
    k = wkey(a);
    exp_hit = BUF_EN && r && !w && bvalid && (bword == k);
    access(r, w, a, d, lat, rdat, wl, oh);
    chk({tag, ".latency"}, 32'(lat), exp_hit ? 32'd0 : 32'(LAT));
    chk({tag, ".we_cycles"}, 32'(wl), w ? 32'(2 * (W - 1)) : 32'd0);
    chk({tag, ".oe_cycles"}, 32'(oh), (w && !exp_hit) ? 32'(2 * W) : 32'd0);
    if (w) begin
      ref_mem[k] = d;
      if (bword == k) bvalid = 1'b0;
    end else begin
      chk({tag, ".rdata"}, rdat, ref_get(k));
      bvalid = 1'b1; bword = k;
    end
  endtask

  initial begin
    logic [31:0] rd, a, d;
    int op, k;
    n_asserts = 0; n_fail = 0; bvalid = 1'b0; bword = -1;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst.oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("rst.addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst.dq_out", 32'(SRAM_DQ_out), 32'd0);
    chk("rst.rdata", read_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // write then read of the base word
    txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "wr1024", rd);
    chk("wr1024.hw0", 32'(sram[0]), 32'h0000BEEF);
    chk("wr1024.hw1", 32'(sram[1]), 32'h0000DEAD);
    txn(1'b1, 1'b0, 32'd1024, 32'h0, "rd1024", rd);
    chk("rd1024.value", rd, 32'hDEADBEEF);

    // both enables: write wins; read_data holds across the write
    txn(1'b1, 1'b1, 32'd1028, 32'h12345678, "both1028", rd);
    chk("hold.rdata", read_data, 32'hDEADBEEF);
    chk("both1028.hw2", 32'(sram[2]), 32'h00005678);
    txn(1'b1, 1'b0, 32'd1028, 32'h0, "rd1028", rd);
    chk("rd1028.value", rd, 32'h12345678);

    // address below the base wraps to the top of the SRAM
    txn(1'b0, 1'b1, BASE - 32'd4, 32'hA5A55A5A, "wrap", rd);
    chk("wrap.hw_lo", 32'(sram[18'h3FFFE]), 32'h00005A5A);
    chk("wrap.hw_hi", 32'(sram[18'h3FFFF]), 32'h0000A5A5);

    // reset in the third LOW cycle of a write
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.we_n", 32'(SRAM_WE_N), 32'd1);
    chk("midrst.oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("midrst.addr", 32'(SRAM_ADDR), 32'd0);
    chk("midrst.dq_out", 32'(SRAM_DQ_out), 32'd0);
    chk("midrst.rdata", read_data, 32'd0);
    chk("midrst.ready_req", 32'(ready), 32'd0);
    wr_en = 1'b0;
    #1;
    chk("midrst.ready_idle", 32'(ready), 32'd1);
    bvalid = 1'b0;
    ref_mem.delete(wkey(32'd1032));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 32'd1032, 32'h0BADC0DE, "postrst.wr", rd);
    txn(1'b1, 1'b0, 32'd1032, 32'h0, "postrst.rd", rd);
    chk("postrst.value", rd, 32'h0BADC0DE);

`ifdef SRAM_RD_BUF_EN
    // back-to-back reads hit, a write to the word forces a full access
    txn(1'b1, 1'b0, 32'd1024, 32'h0, "buf.rd1", rd);
    txn(1'b1, 1'b0, 32'd1024, 32'h0, "buf.rd2", rd);
    chk("buf.rd2.value", rd, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 32'd1024, 32'h1, "buf.wr", rd);
    txn(1'b1, 1'b0, 32'd1024, 32'h0, "buf.rd3", rd);
    chk("buf.rd3.value", rd, 32'h1);
`endif

    // randomized mix over a small word set, including the wrap word
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 7);
      a  = (k == 7) ? BASE - 32'd4 : BASE + 32'(4 * k);
      op = $urandom_range(0, 2);
      d  = $urandom;
      txn(op != 1, op != 0, a, d, $sformatf("rand%0d", i), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 5, meaning SRAM clock cycles per halfword phase (legal range 2..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024, meaning the CPU byte address mapped to SRAM halfword 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rd_en  input  1  MEM-stage read request, held until ready.
REQ-006 SHALL have port wr_en  input  1  MEM-stage write request, held until ready.
REQ-007 SHALL have port address  input  32  CPU byte address (ALU result), word-aligned.
REQ-008 SHALL have port write_data  input  32  store data (Val_Rm).
REQ-009 SHALL have port read_data  output  32  load data, valid while ready=1 after a read.
REQ-010 SHALL have port ready  output  1  access complete; the pipeline freezes while 0.
REQ-011 SHALL have port SRAM_ADDR  output  18  SRAM halfword address.
REQ-012 SHALL have port SRAM_DQ_in  input  16  SRAM data bus, read direction.
REQ-013 SHALL have port SRAM_DQ_out  output  16  SRAM data bus, write direction.
REQ-014 SHALL have port SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto the bus.
REQ-015 SHALL have port SRAM_WE_N  output  1  SRAM write strobe, active-low.

Function
REQ-016 SHALL implement FSM states IDLE, LOW, HIGH, DONE with a 4-bit phase counter.
REQ-017 SHALL form word = (address - BASE_ADDR)[18:2] and drive SRAM_ADDR = {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH, with the 18-bit result wrapping modulo 2^18.
REQ-018 SHALL, in IDLE with rd_en|wr_en = 1, drive ready=0 combinationally, latch op/address/write_data, and enter LOW.
REQ-019 SHALL, in IDLE with no request, drive ready=1.
REQ-020 SHALL remain in LOW and then HIGH for exactly WAIT_CYCLES cycles each, then spend one cycle in DONE (ready=1), then return unconditionally to IDLE; request-to-ready latency = 2*WAIT_CYCLES+1 cycles.
REQ-021 SHALL, for a write, drive SRAM_DQ_oe=1 with write_data[15:0] in LOW and [31:16] in HIGH, and SRAM_WE_N=0 on all but the last cycle of each phase.
REQ-022 SHALL, for a read, keep SRAM_DQ_oe=0 and SRAM_WE_N=1, and capture SRAM_DQ_in into read_data[15:0] on the last LOW cycle and into [31:16] on the last HIGH cycle.
REQ-023 SHALL give wr_en priority when rd_en and wr_en are both 1.
REQ-024 SHALL ignore input changes between latch and DONE.
REQ-025 SHALL hold read_data at its last captured value outside reads.

Reset
REQ-026 SHALL, on rst=0 at any time including mid-access, force IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0; ready then follows REQ-018/REQ-019.
REQ-027 SHALL not commit any partial write state after reset; a half-written SRAM word is acceptable.

Configuration
REQ-028 SHALL support macro SRAM_RD_BUF_EN.
REQ-029 SHALL, with SRAM_RD_BUF_EN defined, keep a one-entry buffer (valid, word, data): a read in IDLE whose word matches a valid entry returns the buffered data with ready=1 in the same cycle and no SRAM access; any write to the same word invalidates the entry; reset clears valid; each completed read refills the buffer.
REQ-030 SHALL, with SRAM_RD_BUF_EN undefined, contain no buffer, so every read takes 2*WAIT_CYCLES+1 cycles.

Verification
REQ-031 SHALL verify: reset, then a write of 0xDEADBEEF at address 1024 -> SRAM halfword 0 = 0xBEEF, halfword 1 = 0xDEAD, and ready=1 exactly 11 cycles after the request (WAIT_CYCLES=5).
REQ-032 SHALL verify: a read at 1024 after REQ-031 -> read_data=0xDEADBEEF with ready=1 in cycle 11, and SRAM_WE_N=1 throughout.
REQ-033 SHALL verify: rd_en=wr_en=1 at 1028 with data 0x12345678 -> a write occurs, and a subsequent read returns 0x12345678.
REQ-034 SHALL verify: rst=0 asserted in cycle 3 of LOW during a write -> all outputs take their reset values immediately, and the next request completes normally.
REQ-035 SHALL verify, with SRAM_RD_BUF_EN: two back-to-back reads of 1024 -> the second has ready=1 in the same cycle; a write of 0x1 to 1024 followed by a read -> full latency and read_data=0x1.
